cc_tag_ctrl: RTL and testbench
==============================

// Module: cc_tag_ctrl
// PURPOSE
//  Sequencer for one coherence-cache tag way-group: after reset sweeps all sets with init, then
//  arbitrates fill and invalidate requesters onto the single tag write port (write_phys_addr/
//  write_wen/invalidate), samples write_hit/write_exp_en one cycle later, retries unplaced fills
//  and hands evicted line addresses to the writeback path with a valid/ready handshake.
// PARAMETERS
//  ADDR_W      37  tag physical line address width (PHYS_BITS-7)
//  SETS_LOG2   6   log2 of sets swept during init
//  MAX_RETRY   3   re-issues of a request whose write_hit stays low before done_err
// PORTS
//  clk            in   1       clock; all state updates on negedge clk, as the tag arrays do
//  rst            in   1       synchronous, active-high reset
//  fill_req       in   1       fill request; hold with fill_addr until fill_ack
//  fill_addr      in   ADDR_W  fill line address
//  fill_ack       out  1       1-cycle pulse: fill accepted
//  inv_req        in   1       invalidate request; hold with inv_addr until inv_ack
//  inv_addr       in   ADDR_W  invalidate line address
//  inv_ack        out  1       1-cycle pulse: invalidate accepted
//  tag_init       out  1       to tag init
//  tag_write_wen  out  1       to tag write_wen
//  tag_invalidate out  1       to tag invalidate
//  tag_write_addr out  ADDR_W  to tag write_phys_addr
//  tag_write_hit  in   1       from tag write_hit
//  tag_exp_en     in   1       from tag write_exp_en
//  tag_expun_addr in   ADDR_W  from tag write_expun_addr
//  evict_valid    out  1       evicted line address valid
//  evict_addr     out  ADDR_W  evicted line address
//  evict_ready    in   1       writeback path accepts evict_addr
//  done_valid     out  1       1-cycle pulse: request retired
//  done_inv       out  1       qualifies done_valid: retired request was an invalidate
//  done_err       out  1       qualifies done_valid: retries exhausted, nothing written
//  busy           out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=INIT, set counter=0, retry=0, fair=0; all outputs 0 except tag_init=1, busy=1.
//  INIT: tag_init=1, tag_write_addr[SETS_LOG2-1:0]=counter, upper bits 0; counter+1 per cycle;
//   counter==2^SETS_LOG2-1 -> DRAIN. DRAIN: 2 cycles, tag_init=0, covers init_reg/init_reg2 -> IDLE.
//  IDLE: no acks in INIT/DRAIN. inv_req&!fill_req -> inv; fill_req&!inv_req -> fill;
//   both -> inv unless fair=1, then fill. fair<=1 after an inv grant with fill_req high, 0 after a
//   fill grant. Grant: ack pulse, latch addr/kind, retry=0 -> ISSUE.
//  ISSUE (1 cyc): tag_write_wen=1, tag_write_addr=latched, tag_invalidate=kind==inv -> RESP.
//  RESP (1 cyc): sample tag_write_hit (valid 1 cycle after wen, tag registers write side).
//   hit&exp_en -> latch tag_expun_addr, EVICT. hit&!exp_en -> done_valid next cycle, IDLE.
//   !hit&retry<MAX_RETRY -> retry+1, ISSUE. !hit&retry==MAX_RETRY -> done_valid+done_err, IDLE.
//  EVICT: evict_valid=1, evict_addr stable until evict_valid&evict_ready; then done_valid
//   next cycle, IDLE. An invalidate removing a valid line is also an eviction.
//  Latency: grant->ISSUE 1 cyc, ->RESP 2, idle retire at cycle 3 (ack at 0). Throughput 1 req/4 cyc.
//  Only one request in flight; addr latched at grant, input changes after ack ignored.
//  done_inv/done_err are 0 whenever done_valid=0.
//  rst mid-operation: abort in-flight request, no done_valid, drop evict_valid same edge, redo INIT.
//  Retry counter width clog2(MAX_RETRY+1); no wrap possible.
// CONFIGURATION
//  CC_TAG_CTRL_STATS_EN defined: adds outputs stat_fill[31:0], stat_evict[31:0],
//   stat_retry[31:0]: saturating counts of retired fills, evict handshakes, re-issues; 0 on rst.
//  Not defined: ports and counters absent; control behaviour identical.
// TESTING
//  rst 1 cyc -> tag_init high 64 cycles, addr 0..63, then 2 idle-init cycles, busy low cycle 67.
//  fill_req addr=0x1_2345, hit=1, exp_en=0 -> fill_ack t0, wen t1, done_valid t3, done_err=0.
//  inv_req+fill_req same cycle twice -> grant order inv, fill, inv (fair bit alternates).
//  fill, exp_en=1, expun=0x0_0ABC, evict_ready low 5 cyc -> evict_valid held 6 cyc, addr stable, done after.
//  write_hit=0 always -> 4 ISSUE pulses (MAX_RETRY=3), done_valid with done_err=1, no eviction.
//  rst asserted in EVICT -> evict_valid 0 next cycle, no done_valid, tag_init sweep restarts at 0.

Source files
------------

// File: rtl/cc_tag_ctrl.sv
// Tag way-group sequencer: init sweep, fill/invalidate arbitration, retry and eviction handshake.
// Define CC_TAG_CTRL_STATS_EN to add saturating fill/evict/retry counters.
module cc_tag_ctrl #(
  parameter int unsigned ADDR_W    = 37,
  parameter int unsigned SETS_LOG2 = 6,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_req,
  input  logic [ADDR_W-1:0] fill_addr,
  output logic              fill_ack,
  input  logic              inv_req,
  input  logic [ADDR_W-1:0] inv_addr,
  output logic              inv_ack,
  output logic              tag_init,
  output logic              tag_write_wen,
  output logic              tag_invalidate,
  output logic [ADDR_W-1:0] tag_write_addr,
  input  logic              tag_write_hit,
  input  logic              tag_exp_en,
  input  logic [ADDR_W-1:0] tag_expun_addr,
  output logic              evict_valid,
  output logic [ADDR_W-1:0] evict_addr,
  input  logic              evict_ready,
  output logic              done_valid,
  output logic              done_inv,
  output logic              done_err,
  output logic              busy
`ifdef CC_TAG_CTRL_STATS_EN
  ,
  output logic [31:0]       stat_fill,
  output logic [31:0]       stat_evict,
  output logic [31:0]       stat_retry
`endif
);

  localparam int unsigned   RW_RAW    = $clog2(MAX_RETRY + 1);
  localparam int unsigned   RW        = (RW_RAW == 0) ? 1 : RW_RAW;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_INIT,
    S_DRAIN,
    S_IDLE,
    S_GRANT,
    S_ISSUE,
    S_RESP,
    S_EVICT
  } state_e;

  state_e               state_q;
  logic [SETS_LOG2-1:0] cnt_q;
  logic [SETS_LOG2-1:0] cnt_d;
  logic [RW-1:0]        retry_q;
  logic                 fair_q;
  logic                 kind_inv_q;
  logic [ADDR_W-1:0]    req_addr_q;

  logic              fill_ack_q, inv_ack_q, tag_init_q, tag_wen_q, tag_inv_q;
  logic [ADDR_W-1:0] tag_addr_q, evict_addr_q;
  logic              evict_valid_q, done_valid_q, done_inv_q, done_err_q, busy_q;

  logic grant_inv_d, grant_fill_d;

  // Invalidates win a tie unless the previous tie went to an invalidate.
  always_comb begin
    grant_inv_d  = inv_req & (~fill_req | ~fair_q);
    grant_fill_d = fill_req & ~grant_inv_d;
    cnt_d        = cnt_q + 1'b1;
  end

  // State advances on the falling edge so the tag arrays see stable controls at their own edge.
  always_ff @(negedge clk) begin
    fill_ack_q   <= 1'b0;
    inv_ack_q    <= 1'b0;
    tag_wen_q    <= 1'b0;
    tag_inv_q    <= 1'b0;
    done_valid_q <= 1'b0;
    done_inv_q   <= 1'b0;
    done_err_q   <= 1'b0;
    if (rst) begin
      state_q       <= S_INIT;
      cnt_q         <= '0;
      retry_q       <= '0;
      fair_q        <= 1'b0;
      kind_inv_q    <= 1'b0;
      req_addr_q    <= '0;
      tag_init_q    <= 1'b1;
      tag_addr_q    <= '0;
      evict_valid_q <= 1'b0;
      evict_addr_q  <= '0;
      busy_q        <= 1'b1;
    end else begin
      case (state_q)
        S_INIT: begin
          cnt_q <= cnt_d;
          if (cnt_q == '1) begin
            state_q    <= S_DRAIN;
            tag_init_q <= 1'b0;
            tag_addr_q <= '0;
          end else begin
            tag_addr_q <= ADDR_W'(cnt_d);
          end
        end
        S_DRAIN: begin
          cnt_q <= cnt_d;
          if (cnt_q[0]) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (grant_inv_d || grant_fill_d) begin
            state_q    <= S_GRANT;
            busy_q     <= 1'b1;
            retry_q    <= '0;
            kind_inv_q <= grant_inv_d;
            fill_ack_q <= grant_fill_d;
            inv_ack_q  <= grant_inv_d;
            req_addr_q <= grant_inv_d ? inv_addr : fill_addr;
            if (grant_inv_d && fill_req) fair_q <= 1'b1;
            else if (grant_fill_d)       fair_q <= 1'b0;
          end
        end
        S_GRANT: begin
          state_q    <= S_ISSUE;
          tag_wen_q  <= 1'b1;
          tag_inv_q  <= kind_inv_q;
          tag_addr_q <= req_addr_q;
        end
        S_ISSUE: begin
          state_q    <= S_RESP;
          tag_addr_q <= '0;
        end
        S_RESP: begin
          if (tag_write_hit) begin
            if (tag_exp_en) begin
              state_q       <= S_EVICT;
              evict_valid_q <= 1'b1;
              evict_addr_q  <= tag_expun_addr;
            end else begin
              state_q      <= S_IDLE;
              busy_q       <= 1'b0;
              done_valid_q <= 1'b1;
              done_inv_q   <= kind_inv_q;
            end
          end else if (retry_q != RETRY_MAX) begin
            state_q    <= S_ISSUE;
            retry_q    <= retry_q + 1'b1;
            tag_wen_q  <= 1'b1;
            tag_inv_q  <= kind_inv_q;
            tag_addr_q <= req_addr_q;
          end else begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_valid_q <= 1'b1;
            done_inv_q   <= kind_inv_q;
            done_err_q   <= 1'b1;
          end
        end
        S_EVICT: begin
          if (evict_ready) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            evict_valid_q <= 1'b0;
            done_valid_q  <= 1'b1;
            done_inv_q    <= kind_inv_q;
          end
        end
        default: begin
          state_q    <= S_INIT;
          cnt_q      <= '0;
          tag_init_q <= 1'b1;
          tag_addr_q <= '0;
          busy_q     <= 1'b1;
        end
      endcase
    end
  end

  assign fill_ack       = fill_ack_q;
  assign inv_ack        = inv_ack_q;
  assign tag_init       = tag_init_q;
  assign tag_write_wen  = tag_wen_q;
  assign tag_invalidate = tag_inv_q;
  assign tag_write_addr = tag_addr_q;
  assign evict_valid    = evict_valid_q;
  assign evict_addr     = evict_addr_q;
  assign done_valid     = done_valid_q;
  assign done_inv       = done_inv_q;
  assign done_err       = done_err_q;
  assign busy           = busy_q;

`ifdef CC_TAG_CTRL_STATS_EN
  logic [31:0] stat_fill_q, stat_evict_q, stat_retry_q;

  always_ff @(negedge clk) begin
    if (rst) begin
      stat_fill_q  <= '0;
      stat_evict_q <= '0;
      stat_retry_q <= '0;
    end else begin
      if (done_valid_q && !done_inv_q && stat_fill_q != '1)
        stat_fill_q <= stat_fill_q + 32'd1;
      if (state_q == S_EVICT && evict_ready && stat_evict_q != '1)
        stat_evict_q <= stat_evict_q + 32'd1;
      if (state_q == S_RESP && !tag_write_hit && retry_q != RETRY_MAX && stat_retry_q != '1)
        stat_retry_q <= stat_retry_q + 32'd1;
    end
  end

  assign stat_fill  = stat_fill_q;
  assign stat_evict = stat_evict_q;
  assign stat_retry = stat_retry_q;
`endif

endmodule

// File: tb/tb_cc_tag_ctrl.sv
// Randomized scoreboard bench for cc_tag_ctrl: driver predicts grants, monitor checks tag traffic and retirement.
module tb_cc_tag_ctrl;

  localparam int unsigned AW = 37;

  logic          clk = 1'b0;
  logic          rst;
  logic          fill_req, inv_req;
  logic [AW-1:0] fill_addr, inv_addr;
  logic          fill_ack, inv_ack;
  logic          tag_init, tag_write_wen, tag_invalidate;
  logic [AW-1:0] tag_write_addr;
  logic          tag_write_hit, tag_exp_en;
  logic [AW-1:0] tag_expun_addr;
  logic          evict_valid, evict_ready;
  logic [AW-1:0] evict_addr;
  logic          done_valid, done_inv, done_err, busy;
`ifdef CC_TAG_CTRL_STATS_EN
  logic [31:0]   stat_fill, stat_evict, stat_retry;
`endif

  cc_tag_ctrl #(.ADDR_W(AW), .SETS_LOG2(6), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst),
    .fill_req(fill_req), .fill_addr(fill_addr), .fill_ack(fill_ack),
    .inv_req(inv_req), .inv_addr(inv_addr), .inv_ack(inv_ack),
    .tag_init(tag_init), .tag_write_wen(tag_write_wen), .tag_invalidate(tag_invalidate),
    .tag_write_addr(tag_write_addr), .tag_write_hit(tag_write_hit), .tag_exp_en(tag_exp_en),
    .tag_expun_addr(tag_expun_addr), .evict_valid(evict_valid), .evict_addr(evict_addr),
    .evict_ready(evict_ready), .done_valid(done_valid), .done_inv(done_inv),
    .done_err(done_err), .busy(busy)
`ifdef CC_TAG_CTRL_STATS_EN
    , .stat_fill(stat_fill), .stat_evict(stat_evict), .stat_retry(stat_retry)
`endif
  );

  always #5 clk = ~clk;

  // misses: write attempts answered with hit=0 before a hit; 4 means the tag never hits.
  typedef struct {
    logic          inv;
    logic [AW-1:0] addr;
    int unsigned   misses;
    logic          exp;
    logic [AW-1:0] expun;
    int unsigned   delay;
  } txn_t;

  txn_t gq[$];
  txn_t inq[$];

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got event want none", nm);
  endtask

  function automatic int unsigned n_issue(input txn_t t);
    return (t.misses >= 4) ? 4 : t.misses + 1;
  endfunction

  function automatic logic is_err(input txn_t t);
    return t.misses >= 4;
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[AW-1:0];
  endfunction

  function automatic txn_t rnd_txn(input logic inv);
    txn_t        t;
    int unsigned r;
    r        = $urandom_range(0, 9);
    t.inv    = inv;
    t.addr   = rnd_addr();
    t.misses = (r < 5) ? 0 : (r < 8) ? $urandom_range(1, 3) : 4;
    t.exp    = 1'($urandom_range(0, 1));
    t.expun  = rnd_addr();
    t.delay  = $urandom_range(0, 4);
    return t;
  endfunction

  // Monitor / tag-array responder
  int          cyc = 0;
  int          ack_cyc, hs_cyc;
  int unsigned wen_n, ev_n;
  txn_t        mt;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (armed) begin
        if (fill_ack || inv_ack) begin
          if (gq.size() == 0) flag("ack_unexpected");
          else begin
            mt = gq.pop_front();
            chk("ack_kind", {62'b0, inv_ack, fill_ack}, {62'b0, mt.inv, ~mt.inv});
            chk("ack_while_inflight", inq.size(), 0);
            inq.push_back(mt);
            ack_cyc = cyc;
            wen_n   = 0;
            ev_n    = 0;
          end
        end
        if (tag_write_wen) begin
          if (inq.size() == 0) flag("wen_unexpected");
          else begin
            mt = inq[0];
            chk("wen_addr", tag_write_addr, mt.addr);
            chk("wen_invalidate", tag_invalidate, mt.inv);
            chk("wen_cycle", cyc, ack_cyc + 1 + 2 * wen_n);
            tag_write_hit  = (wen_n >= mt.misses);
            tag_exp_en     = mt.exp;
            tag_expun_addr = mt.expun;
            wen_n++;
          end
        end
        if (evict_valid) begin
          if (inq.size() == 0) flag("evict_unexpected");
          else begin
            mt = inq[0];
            if (ev_n == 0) begin
              chk("evict_expected", 1, {63'b0, !is_err(mt) && mt.exp});
              chk("evict_start", cyc, ack_cyc + 2 * n_issue(mt) + 1);
            end
            chk("evict_addr", evict_addr, mt.expun);
            ev_n++;
            evict_ready = (ev_n > mt.delay);
            if (evict_ready) hs_cyc = cyc;
          end
        end else begin
          evict_ready = 1'($urandom_range(0, 1));
        end
        if (done_valid) begin
          if (inq.size() == 0) flag("done_unexpected");
          else begin
            mt = inq.pop_front();
            chk("done_inv", done_inv, mt.inv);
            chk("done_err", done_err, is_err(mt));
            chk("issue_count", wen_n, n_issue(mt));
            chk("busy_at_done", busy, 0);
            if (!is_err(mt) && mt.exp) begin
              chk("done_after_evict", cyc, hs_cyc + 1);
              chk("evict_hold", ev_n, mt.delay + 1);
            end else begin
              chk("done_latency", cyc, ack_cyc + 2 * n_issue(mt) + 1);
              chk("no_evict", ev_n, 0);
            end
          end
        end else begin
          chk("done_quals_idle", {62'b0, done_inv, done_err}, 0);
        end
      end
    end
  end

  // Driver with a high-level arbitration model
  bit   m_fair = 1'b0;
  bit   p_inv = 1'b0, p_fill = 1'b0;
  txn_t t_inv, t_fill;

  task automatic raise(input txn_t t);
    if (t.inv) begin
      t_inv = t; p_inv = 1'b1; inv_req = 1'b1; inv_addr = t.addr;
    end else begin
      t_fill = t; p_fill = 1'b1; fill_req = 1'b1; fill_addr = t.addr;
    end
  endtask

  task automatic grant_step();
    bit w_inv;
    bit got;
    w_inv = p_inv && (!p_fill || !m_fair);
    gq.push_back(w_inv ? t_inv : t_fill);
    if (w_inv && p_fill) m_fair = 1'b1;
    else if (!w_inv)     m_fair = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      if (fill_ack || inv_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("grant_timeout", 0, 1);
    if (w_inv) begin
      p_inv = 1'b0; inv_req = 1'b0; inv_addr = rnd_addr();
    end else begin
      p_fill = 1'b0; fill_req = 1'b0; fill_addr = rnd_addr();
    end
  endtask

  // Called at the first sample point after the reset edge.
  task automatic sweep_check();
    for (int c = 0; c < 67; c++) begin
      if (c > 0) @(posedge clk);
      if (c == 0) begin
        chk("rst_acks", {62'b0, fill_ack, inv_ack}, 0);
        chk("rst_wen", {62'b0, tag_write_wen, tag_invalidate}, 0);
        chk("rst_evict_valid", evict_valid, 0);
        chk("rst_done", {61'b0, done_valid, done_inv, done_err}, 0);
      end
      chk("init_level", tag_init, (c < 64) ? 1 : 0);
      chk("init_addr", tag_write_addr, (c < 64) ? c : 0);
      chk("init_busy", busy, (c < 66) ? 1 : 0);
      chk("init_no_done", done_valid, 0);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 600; i++) begin
      if (gq.size() == 0 && inq.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_pending", gq.size() + inq.size(), 0);
  endtask

  initial begin
    txn_t t;
    bit   seen;
    rst = 1'b1; fill_req = 1'b0; inv_req = 1'b0; fill_addr = '0; inv_addr = '0;
    tag_write_hit = 1'b0; tag_exp_en = 1'b0; tag_expun_addr = '0; evict_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    rst = 1'b0;
    sweep_check();
    armed = 1'b1;

    t = '{inv: 1'b0, addr: 37'h1_2345, misses: 0, exp: 1'b0, expun: '0, delay: 0};
    raise(t); grant_step();

    // Simultaneous requests: inv, then fill, then inv again
    t = rnd_txn(1'b1); raise(t);
    t = rnd_txn(1'b0); raise(t);
    grant_step();
    t = rnd_txn(1'b1); raise(t);
    grant_step();
    grant_step();

    t = '{inv: 1'b0, addr: rnd_addr(), misses: 0, exp: 1'b1, expun: 37'h0_0ABC, delay: 5};
    raise(t); grant_step();
    t = '{inv: 1'b0, addr: rnd_addr(), misses: 4, exp: 1'b1, expun: rnd_addr(), delay: 0};
    raise(t); grant_step();
    t = '{inv: 1'b1, addr: rnd_addr(), misses: 2, exp: 1'b1, expun: rnd_addr(), delay: 2};
    raise(t); grant_step();

    for (int n = 0; n < 40; n++) begin
      int unsigned sel;
      sel = $urandom_range(0, 2);
      if (!p_inv && sel != 0)  begin t = rnd_txn(1'b1); raise(t); end
      if (!p_fill && sel != 1) begin t = rnd_txn(1'b0); raise(t); end
      grant_step();
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    while (p_inv || p_fill) grant_step();
    wait_drain();

    // Reset while an eviction is waiting for the writeback path
    t = '{inv: 1'b0, addr: rnd_addr(), misses: 0, exp: 1'b1, expun: rnd_addr(), delay: 1000};
    raise(t); grant_step();
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (evict_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("evict_before_rst", seen, 1);
    armed = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    rst = 1'b0;
    sweep_check();
    gq.delete();
    inq.delete();
    m_fair = 1'b0;
    armed = 1'b1;

    t = rnd_txn(1'b0); t.misses = 0; raise(t); grant_step();
    t = rnd_txn(1'b1); raise(t); grant_step();
    wait_drain();
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
